// File: rtl/u111_dynamic_sizer.sv
// u111_dynamic_sizer: splits 68040 long/word/byte/line transfers into 8/16/32-bit local-bus sub-cycles
module u111_dynamic_sizer #(
  parameter int TIMEOUT = 255,
  parameter int LINE_AS_LONG = 1
) (
  input  logic        CLK80,
  input  logic        RESET,
  input  logic        TS_CPUn,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [1:0]  A_040,
  input  logic [1:0]  PORTSIZE,
  input  logic        TACKn,
  input  logic [31:0] D_CPU_WR,
  input  logic [31:0] D_AMIGA_RD,
  output logic        TSn,
  output logic        TAn,
  output logic        TBI_CPUn,
  output logic        TEA_CPUn,
  output logic [1:0]  A_AMIGA,
  output logic [31:0] D_AMIGA_WR,
  output logic        D_AMIGA_OE,
  output logic [31:0] D_CPU_RD,
  output logic        D_CPU_OE,
  output logic        BUSY
);
  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR} state_t;
  state_t state, nxt;
  logic rnw_q, ack, expired, is_long, p8, p16, wr_now;
  logic [1:0] siz_q, ps_q, k, k_last, step, a1, ia, ia1;
  logic [15:0] cnt;
  logic [31:0] wr_q;
  logic [3:0][7:0] wr_b, asm_q;
  assign wr_b = wr_q;
  assign D_CPU_RD = asm_q;
  always_comb begin
    p8 = ps_q == 2'b01;
    p16 = ps_q == 2'b10;
    is_long = siz_q == 2'b00 || siz_q == 2'b11;
    k_last = p8 ? (is_long ? 2'd3 : siz_q == 2'b10 ? 2'd1 : 2'd0) : (p16 && is_long) ? 2'd1 : 2'd0;
    step = p8 ? 2'd1 : p16 ? 2'd2 : 2'd0;
    a1 = A_AMIGA + 2'd1;
    ia = ~A_AMIGA;
    ia1 = ~a1;
    ack = state == WAIT && !TACKn;
    expired = state == WAIT && TACKn && cnt == 16'(TIMEOUT - 1);
    wr_now = state == IDLE ? !RnW : !rnw_q;
    nxt = state == IDLE ? (TS_CPUn ? IDLE : START)
        : state == START ? WAIT
        : state == WAIT ? (ack ? (k == k_last ? DONE : START) : expired ? ERR : WAIT)
        : IDLE;
    D_AMIGA_WR = p8 ? {wr_b[ia], wr_q[23:0]} : p16 ? {wr_b[ia], wr_b[ia1], wr_q[15:0]} : wr_q;
  end
  always_ff @(posedge CLK80) begin
    if (RESET) begin
      state <= IDLE;
      TSn <= 1'b1;
      TAn <= 1'b1;
      TBI_CPUn <= 1'b1;
      TEA_CPUn <= 1'b1;
      D_AMIGA_OE <= 1'b0;
      D_CPU_OE <= 1'b0;
      BUSY <= 1'b0;
      A_AMIGA <= 2'b00;
      k <= 2'd0;
      cnt <= '0;
      asm_q <= '0;
      rnw_q <= 1'b1;
      siz_q <= 2'b00;
      ps_q <= 2'b00;
      wr_q <= '0;
    end else begin
      state <= nxt;
      TSn <= nxt != START;
      TAn <= nxt != DONE;
      TEA_CPUn <= nxt != ERR;
      TBI_CPUn <= !(nxt == DONE && siz_q == 2'b11 && LINE_AS_LONG != 0);
      D_CPU_OE <= nxt == DONE && rnw_q;
      D_AMIGA_OE <= (nxt == START || nxt == WAIT) && wr_now;
      BUSY <= nxt != IDLE;
      cnt <= state == START ? '0 : (state == WAIT && TACKn) ? cnt + 16'd1 : cnt;
      if (state == IDLE && !TS_CPUn) begin
        rnw_q <= RnW;
        siz_q <= SIZ;
        ps_q <= PORTSIZE;
        wr_q <= D_CPU_WR;
        k <= 2'd0;
        A_AMIGA <= (SIZ == 2'b00 || SIZ == 2'b11) ? 2'b00 : A_040;
      end
      if (ack) begin
        if (rnw_q) begin
          if (p8) asm_q[ia] <= D_AMIGA_RD[31:24];
          else if (p16) begin
            asm_q[ia] <= D_AMIGA_RD[31:24];
            asm_q[ia1] <= D_AMIGA_RD[23:16];
          end else asm_q <= D_AMIGA_RD;
        end
        if (k != k_last) begin
          k <= k + 2'd1;
          A_AMIGA <= A_AMIGA + step;
        end
      end
      if (nxt == ERR && rnw_q) asm_q <= '0;
    end
  end
endmodule

// File: tb/tb_u111_dynamic_sizer.sv
// tb_u111_dynamic_sizer: directed self-checking bench for u111_dynamic_sizer
module tb_u111_dynamic_sizer;
  logic CLK80 = 1'b0, RESET = 1'b1, TS_CPUn = 1'b1, RnW = 1'b1, TACKn = 1'b1;
  logic [1:0] SIZ = 2'b00, A_040 = 2'b00, PORTSIZE = 2'b00;
  logic [31:0] D_CPU_WR = '0, D_AMIGA_RD = '0;
  logic TSn, TAn, TBI_CPUn, TEA_CPUn, D_AMIGA_OE, D_CPU_OE, BUSY;
  logic [1:0] A_AMIGA;
  logic [31:0] D_AMIGA_WR, D_CPU_RD;
  int checks = 0, errors = 0;
  int nts, ta_cyc, tea_cyc, tack_cyc;
  int ts_cyc[4];
  logic [1:0] addr_log[4];
  logic [31:0] wr_log[4];
  logic oe_log[4];
  logic [31:0] rd_vec[4];
  logic got_ta, got_tea, rst_hit, cpu_oe_obs, tbi_obs, addr_stable;
  logic [31:0] rd_obs;
  always #5 CLK80 = ~CLK80;
  u111_dynamic_sizer #(.TIMEOUT(4), .LINE_AS_LONG(1)) dut (
    .CLK80(CLK80), .RESET(RESET), .TS_CPUn(TS_CPUn), .RnW(RnW), .SIZ(SIZ), .A_040(A_040),
    .PORTSIZE(PORTSIZE), .TACKn(TACKn), .D_CPU_WR(D_CPU_WR), .D_AMIGA_RD(D_AMIGA_RD),
    .TSn(TSn), .TAn(TAn), .TBI_CPUn(TBI_CPUn), .TEA_CPUn(TEA_CPUn), .A_AMIGA(A_AMIGA),
    .D_AMIGA_WR(D_AMIGA_WR), .D_AMIGA_OE(D_AMIGA_OE), .D_CPU_RD(D_CPU_RD),
    .D_CPU_OE(D_CPU_OE), .BUSY(BUSY)
  );
  task automatic do_xfer(input logic rw, input logic [1:0] sz, input logic [1:0] a, input logic [1:0] ps,
                         input logic [31:0] wd, input int dly, input logic respond, input logic hold,
                         input int rst_ts);
    nts = 0; got_ta = 0; got_tea = 0; rst_hit = 0; addr_stable = 1;
    ta_cyc = -1; tea_cyc = -1; tack_cyc = -1;
    RnW = rw; SIZ = sz; A_040 = a; PORTSIZE = ps; D_CPU_WR = wd; TS_CPUn = 0;
    @(posedge CLK80); #1;
    if (!hold) TS_CPUn = 1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      TACKn = 1;
      if (TSn === 1'b0 && nts < 4) begin
        ts_cyc[nts] = cyc; addr_log[nts] = A_AMIGA; wr_log[nts] = D_AMIGA_WR; oe_log[nts] = D_AMIGA_OE;
        nts++;
      end
      if (TAn === 1'b0) begin
        got_ta = 1; ta_cyc = cyc; rd_obs = D_CPU_RD; cpu_oe_obs = D_CPU_OE; tbi_obs = TBI_CPUn;
        break;
      end
      if (TEA_CPUn === 1'b0) begin
        got_tea = 1; tea_cyc = cyc;
        break;
      end
      if (nts > 0 && cyc == ts_cyc[nts-1] + dly) begin
        if (nts == rst_ts) begin
          RESET = 1; @(posedge CLK80); #1; RESET = 0; rst_hit = 1;
          break;
        end
        if (respond) begin
          TACKn = 0; D_AMIGA_RD = rd_vec[nts-1]; tack_cyc = cyc;
          if (A_AMIGA !== addr_log[nts-1]) addr_stable = 0;
        end
      end
      @(posedge CLK80); #1;
    end
    TACKn = 1;
  endtask
  task automatic test_reset();
    RESET = 1; repeat (2) @(posedge CLK80); #1;
    checks++; if ({TSn, TAn, TBI_CPUn, TEA_CPUn} !== 4'b1111) begin errors++; $display("FAIL reset_strobes got %b want 1111", {TSn, TAn, TBI_CPUn, TEA_CPUn}); end
    checks++; if ({D_AMIGA_OE, D_CPU_OE, BUSY} !== 3'b000) begin errors++; $display("FAIL reset_enables got %b want 000", {D_AMIGA_OE, D_CPU_OE, BUSY}); end
    checks++; if (A_AMIGA !== 2'b00) begin errors++; $display("FAIL reset_addr got %b want 00", A_AMIGA); end
    checks++; if (D_CPU_RD !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", D_CPU_RD); end
    RESET = 0; @(posedge CLK80); #1;
  endtask
  task automatic test_long_read_16();
    rd_vec[0] = 32'h1234_A5A5; rd_vec[1] = 32'h5678_5A5A;
    do_xfer(1, 2'b00, 2'b00, 2'b10, 32'h0, 1, 1, 0, 0);
    checks++; if (nts !== 2) begin errors++; $display("FAIL lr16_ts_count got %0d want 2", nts); end
    checks++; if ({addr_log[0], addr_log[1]} !== 4'b0010) begin errors++; $display("FAIL lr16_addr got %b want 0010", {addr_log[0], addr_log[1]}); end
    checks++; if (ts_cyc[1] !== 2) begin errors++; $display("FAIL lr16_ts_spacing got %0d want 2", ts_cyc[1]); end
    checks++; if ({got_ta, got_tea} !== 2'b10) begin errors++; $display("FAIL lr16_ack got %b want 10", {got_ta, got_tea}); end
    checks++; if (rd_obs !== 32'h1234_5678) begin errors++; $display("FAIL lr16_data got %h want 12345678", rd_obs); end
    checks++; if ({cpu_oe_obs, tbi_obs, addr_stable} !== 3'b111) begin errors++; $display("FAIL lr16_oe_tbi_addr got %b want 111", {cpu_oe_obs, tbi_obs, addr_stable}); end
    @(posedge CLK80); #1;
    checks++; if ({BUSY, TAn, D_CPU_OE} !== 3'b010) begin errors++; $display("FAIL lr16_after got %b want 010", {BUSY, TAn, D_CPU_OE}); end
    checks++; if (D_CPU_RD !== 32'h1234_5678) begin errors++; $display("FAIL lr16_hold got %h want 12345678", D_CPU_RD); end
  endtask
  task automatic test_long_write_8();
    logic [31:0] w, exp;
    w = 32'hAABB_CCDD;
    do_xfer(0, 2'b00, 2'b00, 2'b01, w, 1, 1, 0, 0);
    checks++; if (nts !== 4) begin errors++; $display("FAIL lw8_ts_count got %0d want 4", nts); end
    for (int i = 0; i < 4; i++) begin
      exp = {w[31-8*i -: 8], w[23:0]};
      checks++; if (addr_log[i] !== 2'(i)) begin errors++; $display("FAIL lw8_addr%0d got %b want %b", i, addr_log[i], 2'(i)); end
      checks++; if (wr_log[i] !== exp) begin errors++; $display("FAIL lw8_data%0d got %h want %h", i, wr_log[i], exp); end
      checks++; if (oe_log[i] !== 1'b1) begin errors++; $display("FAIL lw8_oe%0d got %b want 1", i, oe_log[i]); end
    end
    checks++; if (ts_cyc[3] !== 6) begin errors++; $display("FAIL lw8_ts_spacing got %0d want 6", ts_cyc[3]); end
    checks++; if (!got_ta || ta_cyc - tack_cyc !== 1) begin errors++; $display("FAIL lw8_ta_latency got %0d want 1", ta_cyc - tack_cyc); end
    checks++; if (cpu_oe_obs !== 1'b0) begin errors++; $display("FAIL lw8_cpu_oe got %b want 0", cpu_oe_obs); end
    @(posedge CLK80); #1;
    checks++; if ({BUSY, D_AMIGA_OE} !== 2'b00) begin errors++; $display("FAIL lw8_after got %b want 00", {BUSY, D_AMIGA_OE}); end
  endtask
  task automatic test_word_write_16();
    do_xfer(0, 2'b10, 2'b10, 2'b10, 32'h0000_BEEF, 1, 1, 0, 0);
    checks++; if (nts !== 1) begin errors++; $display("FAIL ww16_ts_count got %0d want 1", nts); end
    checks++; if (addr_log[0] !== 2'b10) begin errors++; $display("FAIL ww16_addr got %b want 10", addr_log[0]); end
    checks++; if (wr_log[0] !== 32'hBEEF_BEEF) begin errors++; $display("FAIL ww16_data got %h want beefbeef", wr_log[0]); end
    checks++; if ({oe_log[0], got_ta} !== 2'b11) begin errors++; $display("FAIL ww16_oe_ta got %b want 11", {oe_log[0], got_ta}); end
    @(posedge CLK80); #1;
  endtask
  task automatic test_byte_read_32();
    int extra;
    rd_vec[0] = 32'hDEAD_BEEF;
    do_xfer(1, 2'b01, 2'b01, 2'b00, 32'h0, 1, 1, 0, 0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK80); #1;
      if (TSn === 1'b0) extra++;
    end
    checks++; if (nts + extra !== 1) begin errors++; $display("FAIL br32_ts_count got %0d want 1", nts + extra); end
    checks++; if (addr_log[0] !== 2'b01) begin errors++; $display("FAIL br32_addr got %b want 01", addr_log[0]); end
    checks++; if (!got_ta || ta_cyc - tack_cyc !== 1) begin errors++; $display("FAIL br32_ta_latency got %0d want 1", ta_cyc - tack_cyc); end
    checks++; if ({tbi_obs, cpu_oe_obs} !== 2'b11) begin errors++; $display("FAIL br32_tbi_oe got %b want 11", {tbi_obs, cpu_oe_obs}); end
    checks++; if (rd_obs !== 32'hDEAD_BEEF) begin errors++; $display("FAIL br32_data got %h want deadbeef", rd_obs); end
  endtask
  task automatic test_line_read();
    rd_vec[0] = 32'h0BAD_F00D;
    do_xfer(1, 2'b11, 2'b11, 2'b00, 32'h0, 1, 1, 0, 0);
    checks++; if ({nts, addr_log[0]} !== {32'd1, 2'b00}) begin errors++; $display("FAIL line_ts_addr got %0d/%b want 1/00", nts, addr_log[0]); end
    checks++; if ({got_ta, tbi_obs} !== 2'b10) begin errors++; $display("FAIL line_tbi got %b want 10", {got_ta, tbi_obs}); end
    checks++; if (rd_obs !== 32'h0BAD_F00D) begin errors++; $display("FAIL line_data got %h want 0badf00d", rd_obs); end
    @(posedge CLK80); #1;
    checks++; if ({TBI_CPUn, BUSY} !== 2'b10) begin errors++; $display("FAIL line_after got %b want 10", {TBI_CPUn, BUSY}); end
  endtask
  task automatic test_timeout();
    do_xfer(1, 2'b00, 2'b00, 2'b00, 32'h0, 1, 0, 0, 0);
    checks++; if ({got_tea, got_ta} !== 2'b10) begin errors++; $display("FAIL to_tea got %b want 10", {got_tea, got_ta}); end
    checks++; if (tea_cyc !== 5) begin errors++; $display("FAIL to_latency got %0d want 5", tea_cyc); end
    @(posedge CLK80); #1;
    checks++; if ({TEA_CPUn, TAn, BUSY} !== 3'b110) begin errors++; $display("FAIL to_after got %b want 110", {TEA_CPUn, TAn, BUSY}); end
    rd_vec[0] = 32'h1357_9BDF;
    do_xfer(1, 2'b00, 2'b00, 2'b00, 32'h0, 4, 1, 0, 0);
    checks++; if ({got_ta, got_tea} !== 2'b10 || ta_cyc !== 5) begin errors++; $display("FAIL to_edge_ack got %b@%0d want 10@5", {got_ta, got_tea}, ta_cyc); end
    checks++; if (rd_obs !== 32'h1357_9BDF) begin errors++; $display("FAIL to_edge_data got %h want 13579bdf", rd_obs); end
    @(posedge CLK80); #1;
  endtask
  task automatic test_reset_mid();
    int stray;
    rd_vec[0] = 32'h1111_0000; rd_vec[1] = 32'h2222_0000;
    do_xfer(1, 2'b11, 2'b00, 2'b10, 32'h0, 1, 1, 0, 2);
    checks++; if ({rst_hit, got_ta, got_tea} !== 3'b100) begin errors++; $display("FAIL rmid_flow got %b want 100", {rst_hit, got_ta, got_tea}); end
    checks++; if ({TSn, TAn, TBI_CPUn, TEA_CPUn} !== 4'b1111) begin errors++; $display("FAIL rmid_strobes got %b want 1111", {TSn, TAn, TBI_CPUn, TEA_CPUn}); end
    checks++; if ({D_AMIGA_OE, D_CPU_OE, BUSY, A_AMIGA} !== 5'b00000) begin errors++; $display("FAIL rmid_state got %b want 00000", {D_AMIGA_OE, D_CPU_OE, BUSY, A_AMIGA}); end
    checks++; if (D_CPU_RD !== 32'h0) begin errors++; $display("FAIL rmid_rd got %h want 0", D_CPU_RD); end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK80); #1;
      if (TAn === 1'b0 || TEA_CPUn === 1'b0 || TSn === 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_stray got %0d want 0", stray); end
    rd_vec[0] = 32'hCAFE_0000; rd_vec[1] = 32'hF00D_0000;
    do_xfer(1, 2'b00, 2'b00, 2'b10, 32'h0, 1, 1, 0, 0);
    checks++; if ({got_ta, nts} !== {1'b1, 32'd2} || rd_obs !== 32'hCAFE_F00D) begin errors++; $display("FAIL rmid_next got %b/%0d/%h want 1/2/cafef00d", got_ta, nts, rd_obs); end
    @(posedge CLK80); #1;
  endtask
  task automatic test_back_to_back();
    rd_vec[0] = 32'h0000_00A5;
    do_xfer(1, 2'b01, 2'b11, 2'b00, 32'h0, 1, 1, 1, 0);
    checks++; if ({got_ta, nts} !== {1'b1, 32'd1}) begin errors++; $display("FAIL b2b_busy_ts got %b/%0d want 1/1", got_ta, nts); end
    @(posedge CLK80); #1;
    checks++; if ({BUSY, TSn} !== 2'b01) begin errors++; $display("FAIL b2b_idle got %b want 01", {BUSY, TSn}); end
    @(posedge CLK80); #1;
    checks++; if ({TSn, A_AMIGA} !== 3'b011) begin errors++; $display("FAIL b2b_accept got %b want 011", {TSn, A_AMIGA}); end
    TS_CPUn = 1;
    @(posedge CLK80); #1;
    TACKn = 0; D_AMIGA_RD = 32'h0000_005A;
    @(posedge CLK80); #1;
    TACKn = 1;
    checks++; if ({TAn, D_CPU_RD} !== {1'b0, 32'h0000_005A}) begin errors++; $display("FAIL b2b_second got %b/%h want 0/0000005a", TAn, D_CPU_RD); end
    @(posedge CLK80); #1;
  endtask
  task automatic test_ignore_tack();
    int bad;
    bad = 0;
    TACKn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK80); #1;
      if (BUSY !== 1'b0 || TAn !== 1'b1 || TSn !== 1'b1) bad++;
    end
    TACKn = 1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_tack got %0d want 0", bad); end
  endtask
  initial begin
    test_reset();
    test_long_read_16();
    test_long_write_8();
    test_word_write_16();
    test_byte_read_32();
    test_line_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_ignore_tack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/u111_dynamic_sizer.md
U111_DYNAMIC_SIZER -- requirements
Module: U111_DYNAMIC_SIZER

Interface
REQ-001 Parameter TIMEOUT, default 255: number of CLK80 cycles waited for _TACK per sub-cycle before the cycle is terminated with an error.
REQ-002 Parameter LINE_AS_LONG, default 1: when 1, a line request (SIZ=11) is run as one long word and TBI is asserted.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Ports, in order:
- CLK80  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high.
- TS_CPUn  in  1  68040 transfer start, active low.
- RnW  in  1  1=read, 0=write.
- SIZ  in  2  00 long, 01 byte, 10 word, 11 line.
- A_040  in  2  CPU address bits 1-0.
- PORTSIZE  in  2  00 32-bit, 01 8-bit, 10 16-bit, 11 treated as 32-bit.
- TACKn  in  1  local-bus acknowledge, active low.
- D_CPU_WR  in  32  CPU write data; byte offset 0 = [31:24].
- D_AMIGA_RD  in  32  local-bus read data.
- TSn  out  1  local-bus transfer start.
- TAn  out  1  CPU transfer acknowledge.
- TBI_CPUn  out  1  CPU burst inhibit.
- TEA_CPUn  out  1  CPU transfer error.
- A_AMIGA  out  2  local-bus address bits 1-0.
- D_AMIGA_WR  out  32  local-bus write data.
- D_AMIGA_OE  out  1  local-bus data drive enable.
- D_CPU_RD  out  32  assembled read data to CPU.
- D_CPU_OE  out  1  CPU data drive enable.
- BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-005 The state machine SHALL have the states IDLE, START, WAIT, DONE and ERR.
REQ-006 Sampling TS_CPUn=0 in IDLE SHALL capture RnW, SIZ, A_040, PORTSIZE and D_CPU_WR, and move to START.
REQ-007 A captured long or line request SHALL have its address forced to 00.
REQ-008 Transfer bytes are 4 for long/line, 2 for word and 1 for byte; port bytes are 4, 2 or 1.
- Sub-cycle count N = max(1, transfer bytes / port bytes): 1, 2 or 4.
REQ-009 START SHALL assert TSn=0 for exactly one clock, clear the timeout counter and go to WAIT.
REQ-010 A_AMIGA SHALL equal the captured address plus k times the port bytes, where k is the sub-cycle index 0..N-1.
- A_AMIGA SHALL be held stable through START and WAIT.
REQ-011 In WAIT, sampling TACKn=0 SHALL end the sub-cycle.
- If k<N-1: increment k and return to START, with no idle clock between them.
- If k=N-1: go to DONE.
REQ-012 Write routing (lanes counted from offset a = A_AMIGA):
- 32-bit port: D_AMIGA_WR = D_CPU_WR.
- 16-bit port: [31:16] = CPU bytes a and a+1.
- 8-bit port: [31:24] = CPU byte a.
- All lanes not named above SHALL carry D_CPU_WR unchanged.
REQ-013 D_AMIGA_OE SHALL be 1 only in START and WAIT of a write.
REQ-014 Read assembly SHALL happen on each TACKn=0 sample:
- 32-bit port: the whole D_AMIGA_RD is latched.
- 16-bit port: D_AMIGA_RD[31:16] is latched into assembly bytes a and a+1.
- 8-bit port: D_AMIGA_RD[31:24] is latched into assembly byte a.
- Unwritten assembly bytes SHALL hold their previous value.
REQ-015 DONE SHALL last one clock.
- TAn=0.
- D_CPU_OE=1 if the transfer is a read.
- TBI_CPUn=0 if SIZ=11 and LINE_AS_LONG=1.
- Then return to IDLE; a new TS_CPUn is accepted in the following clock.
REQ-016 Each WAIT clock without TACKn=0 SHALL increment the timeout counter.
- On reaching TIMEOUT, go to ERR.
- ERR SHALL last one clock with TEA_CPUn=0 and TAn=1, then go to IDLE.
- A partially assembled read SHALL be discarded.
REQ-017 TS_CPUn asserted while not in IDLE SHALL be ignored.
REQ-018 TACKn=0 in IDLE, START, DONE or ERR SHALL be ignored.
REQ-019 TACKn=0 in the same clock as the timeout expiry SHALL take priority, so the sub-cycle completes normally.
REQ-020 D_CPU_RD SHALL hold the assembly register continuously.

Reset
REQ-021 RESET=1 sampled at any clock, including mid-transfer, SHALL take the block to IDLE on that edge.
REQ-022 Outputs after that edge:
- TSn, TAn, TBI_CPUn, TEA_CPUn = 1.
- D_AMIGA_OE, D_CPU_OE, BUSY = 0.
- A_AMIGA = 00.
- k, the timeout counter and the assembly register = 0.
REQ-023 A transfer interrupted by RESET SHALL produce no TAn and no TEA_CPUn.

Verification
REQ-024 Long read, 16-bit port:
- Stimulus: A=00; bus returns 0x1234xxxx, then 0x5678xxxx.
- Response: two TSn pulses with A_AMIGA 00 then 10; a single TAn; D_CPU_RD = 0x12345678.
REQ-025 Long write, 8-bit port:
- Stimulus: D_CPU_WR = 0xAABBCCDD.
- Response: four sub-cycles with A_AMIGA 00, 01, 10, 11 and D_AMIGA_WR[31:24] = AA, BB, CC, DD; TAn after the fourth TACK.
REQ-026 Word write, 16-bit port:
- Stimulus: A=10, D_CPU_WR = 0x0000BEEF.
- Response: one sub-cycle; D_AMIGA_WR[31:16] = 0xBEEF; A_AMIGA = 10.
REQ-027 Byte read, 32-bit port:
- Stimulus: A=01.
- Response: exactly one TSn; TAn 1 clock after TACK; TBI_CPUn stays 1.
REQ-028 Timeout:
- Stimulus: TIMEOUT=4, TACKn held high.
- Response: TEA_CPUn low for one clock, 4 clocks after WAIT is entered; TAn never low; BUSY then 0.
REQ-029 Reset mid-transfer:
- Stimulus: RESET pulsed during the second sub-cycle of a line read with LINE_AS_LONG=1.
- Response: all outputs at their reset values; no TAn; the next transfer runs normally.
